// File: rtl/onebc_pkg.sv
// Shared definitions for the onebc 1-bit computer and its peripherals.
// The event record carries only vec/chg; the timestamp width is a per-instance parameter.
package onebc_pkg;

   localparam int unsigned ONEBC_IO_W      = 8;
   localparam int unsigned ONEBC_DEF_DEPTH = 8;
   localparam int unsigned ONEBC_DEF_TS_W  = 16;

   typedef struct packed {
      logic [ONEBC_IO_W-1:0] vec;
      logic [ONEBC_IO_W-1:0] chg;
   } onebc_ev_t;

endpackage

// File: rtl/onebc_ev_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; head reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module onebc_ev_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               din_i,
   output logic [W-1:0]               dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [W-1:0]  mem [DEPTH];
   logic          wr_en;
   logic          rd_en;

   always_comb begin
      count_o = wr_ptr - rd_ptr;
      empty_o = (wr_ptr == rd_ptr);
      full_o  = (count_o == (AW+1)'(DEPTH));
      rd_en   = pop_i && !empty_o;
      wr_en   = push_i && (!full_o || rd_en);
      dout_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/onebc_out_monitor.sv
// Change monitor for the onebc output bus: registered sample, change detection, event FIFO.
// Define ONEBC_OUT_MONITOR_TSTAMP_EN to add the free-running timestamp counter and stamp storage.
module onebc_out_monitor
   import onebc_pkg::*;
#(
   parameter int unsigned DEPTH = ONEBC_DEF_DEPTH,
   parameter int unsigned TS_W  = ONEBC_DEF_TS_W
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic [ONEBC_IO_W-1:0]      outs_i,
   output logic                       ev_valid_o,
   input  logic                       ev_ready_i,
   output logic [ONEBC_IO_W-1:0]      ev_vec_o,
   output logic [ONEBC_IO_W-1:0]      ev_chg_o,
   output logic [TS_W-1:0]            ev_ts_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o,
   input  logic                       ovf_clr_i
);

   localparam int unsigned EV_W = $bits(onebc_ev_t);
`ifdef ONEBC_OUT_MONITOR_TSTAMP_EN
   localparam int unsigned FW = EV_W + TS_W;
`else
   localparam int unsigned FW = EV_W;
`endif

   logic [ONEBC_IO_W-1:0]  in_q;
   logic [ONEBC_IO_W-1:0]  ref_q;
   logic [ONEBC_IO_W-1:0]  chg;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic                   ovf_set;
   onebc_ev_t              ev_in;
   onebc_ev_t              ev_head;
   logic [FW-1:0]          fifo_din;
   logic [FW-1:0]          fifo_dout;

   always_comb begin
      chg       = in_q ^ ref_q;
      push      = |chg;
      pop       = ev_ready_i && !empty;
      ovf_set   = push && full && !pop;
      ev_in.vec = in_q;
      ev_in.chg = chg;
   end

   // ref_q follows every change, even a dropped one, so later masks are relative to it
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         in_q  <= '0;
         ref_q <= '0;
      end else begin
         in_q <= outs_i;
         if (push) ref_q <= in_q;
      end
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         ovf_o <= 1'b0;
      end else if (ovf_set) begin
         ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
         ovf_o <= 1'b0;
      end
   end

`ifdef ONEBC_OUT_MONITOR_TSTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) ts_q <= '0;
      else         ts_q <= ts_q + TS_W'(1);
   end

   always_comb begin
      fifo_din = {ev_in, ts_q};
      ev_head  = onebc_ev_t'(fifo_dout[FW-1 -: EV_W]);
      ev_ts_o  = fifo_dout[TS_W-1:0];
   end
`else
   always_comb begin
      fifo_din = ev_in;
      ev_head  = onebc_ev_t'(fifo_dout);
      ev_ts_o  = '0;
   end
`endif

   onebc_ev_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

   always_comb begin
      ev_valid_o = !empty;
      ev_vec_o   = ev_head.vec;
      ev_chg_o   = ev_head.chg;
   end

endmodule
